// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 8 x 16 register file: round-robin between the ALU
// and the load unit, registered write port, and a busy-bit scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clock_enable,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_dest,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic [NREG-1:0]   busy
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_e;

  prio_e             prio_q, prio_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic grant_alu, grant_mem, xfer_alu, xfer_mem;

  // Grant depends only on the valids and the priority pointer.
  always_comb begin
    grant_alu = alu_valid & (~mem_valid | (prio_q == PRIO_ALU));
    grant_mem = mem_valid & (~alu_valid | (prio_q == PRIO_MEM));
    xfer_alu  = grant_alu & clock_enable & rst_n;
    xfer_mem  = grant_mem & clock_enable & rst_n;
  end

  assign alu_ready      = xfer_alu;
  assign mem_ready      = xfer_mem;
  // The held write pulse is masked while frozen or in reset so the file never
  // sees a duplicate or a dropped-in-flight write.
  assign reg_write_en   = wen_q & clock_enable & rst_n;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign busy           = busy_q;

  // Next-state for pointer, output stage and scoreboard.
  always_comb begin
    prio_d = prio_q;
    wen_d  = wen_q;
    dest_d = dest_q;
    data_d = data_q;
    busy_d = busy_q;
    if (clock_enable) begin
      wen_d = xfer_alu | xfer_mem;
      if (xfer_alu) begin
        dest_d = alu_dest;
        data_d = alu_data;
        prio_d = PRIO_MEM;
      end else if (xfer_mem) begin
        dest_d = mem_dest;
        data_d = mem_data;
        prio_d = PRIO_ALU;
      end
      // Clear first so a same-edge claim on the same register wins.
      if (wen_q) busy_d[dest_q] = 1'b0;
      if (claim_valid) busy_d[claim_dest] = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= PRIO_ALU;
      wen_q  <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      prio_q <= prio_d;
      wen_q  <= wen_d;
      dest_q <= dest_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model of arbitration and
// scoreboard, expected writes queued at transfer and popped on each write pulse.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clock_enable;
  logic        alu_valid, alu_ready;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [2:0]  mem_dest;
  logic [15:0] mem_data;
  logic        claim_valid;
  logic [2:0]  claim_dest;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [7:0]  busy;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .claim_valid(claim_valid), .claim_dest(claim_dest),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [15:0] rf [8];
  always @(posedge clk) if (reg_write_en === 1'b1) rf[reg_write_dest] <= reg_write_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic        m_prio = 1'b0;
  logic        m_wen  = 1'b0;
  logic [2:0]  m_dest = '0;
  logic [7:0]  m_busy = '0;
  logic [18:0] exp_q [$];

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic cycle(output logic ax, output logic mx);
    logic en, ga, gm, xa, xm;
    logic [18:0] e;
    #2;
    en = clock_enable & rst_n;
    ga = alu_valid & (~mem_valid | ~m_prio);
    gm = mem_valid & (~alu_valid | m_prio);
    xa = ga & en;
    xm = gm & en;
    n_tests++;
    if (alu_ready !== xa) begin n_fail++; $display("FAIL alu_ready: got %b want %b", alu_ready, xa); end
    n_tests++;
    if (mem_ready !== xm) begin n_fail++; $display("FAIL mem_ready: got %b want %b", mem_ready, xm); end
    n_tests++;
    if (reg_write_en !== (m_wen & en)) begin
      n_fail++; $display("FAIL reg_write_en: got %b want %b", reg_write_en, m_wen & en);
    end
    if (reg_write_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL write_unexpected: got dest %0d data %h want none", reg_write_dest, reg_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({reg_write_dest, reg_write_data} !== e) begin
          n_fail++; $display("FAIL write_data: got %0d/%h want %0d/%h", reg_write_dest, reg_write_data, e[18:16], e[15:0]);
        end
      end
    end
    n_tests++;
    if (busy !== m_busy) begin n_fail++; $display("FAIL busy: got %h want %h", busy, m_busy); end
    @(posedge clk);
    if (!rst_n) begin
      m_prio = 1'b0; m_wen = 1'b0; m_dest = '0; m_busy = '0;
      exp_q.delete();
    end else if (clock_enable) begin
      if (m_wen) m_busy[m_dest] = 1'b0;
      if (claim_valid) m_busy[claim_dest] = 1'b1;
      m_wen = xa | xm;
      if (xa) begin exp_q.push_back({alu_dest, alu_data}); m_dest = alu_dest; m_prio = 1'b1; end
      if (xm) begin exp_q.push_back({mem_dest, mem_data}); m_dest = mem_dest; m_prio = 1'b0; end
    end
    #1;
    ax = xa;
    mx = xm;
  endtask

  task automatic test_reset();
    logic ax, mx;
    rst_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
    alu_dest = 3'd6; alu_data = 16'h1234; mem_dest = 3'd7; mem_data = 16'h5678;
    @(posedge clk); #1;
    cycle(ax, mx);
    cycle(ax, mx);
    n_tests++;
    if (reg_write_dest !== 3'd0 || reg_write_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_dest_data: got %0d/%h want 0/0000", reg_write_dest, reg_write_data);
    end
    rst_n = 1'b1;
    cycle(ax, mx);                     // ALU first after reset
    if (ax) alu_valid = 1'b0;
    cycle(ax, mx);                     // MEM next
    if (mx) mem_valid = 1'b0;
    cycle(ax, mx);
    cycle(ax, mx);
  endtask

  task automatic test_single_alu();
    logic ax, mx;
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'hBEEF;
    for (int i = 0; i < 4 && alu_valid; i++) begin
      cycle(ax, mx);
      if (ax) alu_valid = 1'b0;
    end
    cycle(ax, mx);                     // write pulse
    cycle(ax, mx);
    n_tests++;
    if (rf[3] !== 16'hBEEF) begin n_fail++; $display("FAIL rf_r3: got %h want beef", rf[3]); end
  endtask

  task automatic test_scoreboard();
    logic ax, mx;
    claim_valid = 1'b1; claim_dest = 3'd5;
    cycle(ax, mx);
    claim_valid = 1'b0;
    n_tests++;
    if (busy !== 8'h20) begin n_fail++; $display("FAIL busy_claim: got %h want 20", busy); end
    mem_valid = 1'b1; mem_dest = 3'd5; mem_data = 16'hCAFE;
    cycle(ax, mx);
    mem_valid = 1'b0;
    cycle(ax, mx);                     // write pulse edge clears r5
    n_tests++;
    if (busy !== 8'h00) begin n_fail++; $display("FAIL busy_clear: got %h want 00", busy); end
    claim_valid = 1'b1;
    cycle(ax, mx);
    claim_valid = 1'b0;
    mem_valid = 1'b1; mem_data = 16'hD00D;
    cycle(ax, mx);
    mem_valid = 1'b0;
    claim_valid = 1'b1;                // re-claim on the clearing edge
    cycle(ax, mx);
    claim_valid = 1'b0;
    n_tests++;
    if (busy !== 8'h20) begin n_fail++; $display("FAIL busy_set_wins: got %h want 20", busy); end
    cycle(ax, mx);
  endtask

  task automatic test_contention();
    logic ax, mx;
    alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'hA000;
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hB000;
    for (int i = 0; i < 4; i++) begin
      cycle(ax, mx);
      if (ax) alu_data = alu_data + 16'd1;
      if (mx) mem_data = mem_data + 16'd1;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle(ax, mx);
    cycle(ax, mx);
  endtask

  task automatic test_clock_enable();
    logic ax, mx;
    alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'hC000;
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hE000;
    for (int i = 0; i < 9; i++) begin
      clock_enable = !(i >= 2 && i < 5);
      cycle(ax, mx);
      if (ax) alu_data = alu_data + 16'd1;
      if (mx) mem_data = mem_data + 16'd1;
    end
    clock_enable = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle(ax, mx);
    cycle(ax, mx);
  endtask

  task automatic test_reset_mid();
    logic ax, mx;
    alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h4444;
    claim_valid = 1'b1; claim_dest = 3'd6;
    cycle(ax, mx);
    alu_valid = 1'b0; claim_valid = 1'b0;
    rst_n = 1'b0;
    cycle(ax, mx);                     // pulse must be suppressed
    rst_n = 1'b1;
    n_tests++;
    if (busy !== 8'h00) begin n_fail++; $display("FAIL busy_after_reset: got %h want 00", busy); end
    alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'h0A0A;
    mem_valid = 1'b1; mem_dest = 3'd7; mem_data = 16'h0B0B;
    cycle(ax, mx);                     // ALU must win after reset
    if (ax) alu_valid = 1'b0;
    if (mx) mem_valid = 1'b0;
    cycle(ax, mx);
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle(ax, mx);
    cycle(ax, mx);
  endtask

  initial begin
    rst_n = 1'b0; clock_enable = 1'b1;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    claim_valid = 1'b0; claim_dest = '0;
    test_reset();
    test_single_alu();
    test_scoreboard();
    test_contention();
    test_clock_enable();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL writes_missing: got %0d pending want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 8 x 16-bit register file. It shares the file's single write port between two producers, the ALU and the load unit, using round-robin arbitration with a valid/ready handshake. It drives the register file's write-enable, destination and data signals from a registered output stage. It also keeps a busy-bit scoreboard of registers with an outstanding write, which the issue stage reads for hazard stalls.

## Interface
- DATA_W, 16, write data width
- ADDR_W, 3, register address width
- NREG, 8, register count (2**ADDR_W)

- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- clock_enable  in  1  global enable; 0 freezes all state
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load-unit write-back request
- mem_ready  out  1  load request accepted this cycle
- mem_dest  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- claim_valid  in  1  issue stage reserves a destination
- claim_dest  in  ADDR_W  register being reserved
- reg_write_en  out  1  register-file write enable, to the file's write port
- reg_write_dest  out  ADDR_W  register-file write address
- reg_write_data  out  DATA_W  register-file write data
- busy  out  NREG  scoreboard; bit i = 1 means register i has a pending write

## Operation
- Handshake: a transfer occurs on a port when valid & ready are both 1 at a rising clk edge. Requesters hold valid, dest and data stable until the transfer. Valid is never withdrawn before acceptance.
- ready is combinational: port granted & clock_enable & rst_n. Grant depends only on the valids and the priority pointer. No combinational path from ready to valid is allowed.
- Arbitration: at most one grant per cycle.
  - Only one port valid: that port is granted.
  - Both ports valid: the port named by the pointer `prio` (0 = ALU, 1 = MEM) is granted.
  - After every transfer, `prio` moves to the non-granted port.
  - If no transfer occurs, `prio` holds.
- Output stage: on a transfer edge, reg_write_en <= 1 and reg_write_dest/data <= the winner's dest/data. On any other enabled edge, reg_write_en <= 0 and dest/data hold their values.
- Scoreboard:
  - claim_valid at an enabled edge sets busy[claim_dest].
  - An enabled edge with reg_write_en = 1 clears busy[reg_write_dest].
  - When a claim and a clear hit the same register on the same edge, the set wins, so a new producer keeps the register busy.
  - A write to a register that is not busy is legal and leaves it clear.
- clock_enable = 0: no transfer, both ready outputs 0, no state change. reg_write_en is forced to 0 combinationally so the register file cannot double-write.
- Same destination from both ports in consecutive grants: the writes occur in grant order. No merging.

## Timing
- Reset (rst_n = 0 at an edge): reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0, busy = 0, prio = ALU. While rst_n = 0, alu_ready = mem_ready = 0.
- Reset mid-operation drops any transfer in flight; requesters re-present after reset.
- Latency:
  - Transfer at edge N: reg_write_en is high for exactly the cycle after N.
  - The register file captures the data at edge N+1.
  - busy for that register clears at edge N+1.
- Throughput: one write per enabled cycle, back-to-back.
- Fairness: with both ports continuously valid, grants alternate ALU, MEM, ALU, and so on. A waiting requester is accepted within 2 enabled cycles.
- The busy output is registered; a claim at edge N is visible in the cycle after N.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with both valids high -> both readys 0, reg_write_en 0, busy = 8'h00. After release, the ALU is granted first.
- Single ALU request: alu_dest = 3, alu_data = 16'hBEEF, held until ready -> alu_ready high one cycle; the next cycle shows reg_write_en = 1, dest = 3, data = 16'hBEEF; the register file read of r3 returns 16'hBEEF after the following edge.
- Contention: both ports valid for 4 cycles, ALU writing r1 and MEM writing r2 -> grant order ALU, MEM, ALU, MEM; four consecutive write pulses to r1, r2, r1, r2.
- Scoreboard: claim r5 -> busy = 8'h20; MEM write-back to r5 -> busy = 8'h00 on the edge of its write pulse. Claim r5 on that same edge -> busy stays 8'h20.
- clock_enable: drop clock_enable to 0 for 3 cycles mid-contention with a write pulse pending -> reg_write_en 0, readys 0, busy and prio frozen. Raise clock_enable -> sequence resumes with no lost or duplicated write.
- Reset mid-operation: assert rst_n = 0 on the cycle after a transfer -> no write pulse, busy cleared, prio = ALU.
